// File: rtl/pipelined_exec_unit_if.sv
// -----------------------------------------------------------------------------
// pipelined_exec_unit_if
// Instruction-in / result-out bus for pipelined_exec_unit.
//   master : instruction source and result consumer (drives in_valid, rx, ry,
//            rz, op, write_en, out_ready)
//   slave  : the execution unit (drives in_ready, out_valid, result_out,
//            out_rx, zero_flag)
// Parameters must match those of the connected pipelined_exec_unit.
// -----------------------------------------------------------------------------
interface pipelined_exec_unit_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16
);
   localparam int unsigned REG_AW = $clog2(NUM_REGS);

   logic              in_valid;
   logic              in_ready;
   logic [REG_AW-1:0] rx;
   logic [REG_AW-1:0] ry;
   logic [REG_AW-1:0] rz;
   logic [3:0]        op;
   logic              write_en;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result_out;
   logic [REG_AW-1:0] out_rx;
   logic              zero_flag;

   modport master (
      output in_valid, rx, ry, rz, op, write_en, out_ready,
      input  in_ready, out_valid, result_out, out_rx, zero_flag
   );

   modport slave (
      input  in_valid, rx, ry, rz, op, write_en, out_ready,
      output in_ready, out_valid, result_out, out_rx, zero_flag
   );
endinterface

// File: rtl/pipelined_exec_unit.sv
// -----------------------------------------------------------------------------
// pipelined_exec_unit
// Three-stage (read/forward, execute, writeback) register-file + ALU pipeline
// with valid/ready handshakes on input and output, full stall on output
// backpressure, and operand forwarding from EX and WB.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : pipelined_exec_unit_if.slave (instruction in, result out)
// Optional feature macro: ALU_MUL_EN (op 12 = low DATA_W bits of A*B).
// Without it op 12 behaves like ops 13-15: result 0, no register write.
// -----------------------------------------------------------------------------
module pipelined_exec_unit #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ZERO_R0  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   pipelined_exec_unit_if.slave bus
);
   localparam int unsigned REG_AW = $clog2(NUM_REGS);
   localparam int unsigned SH_W   = $clog2(DATA_W);

   logic [DATA_W-1:0] r_regs [NUM_REGS];

   // RD stage
   logic              r_rd_valid;
   logic [REG_AW-1:0] r_rd_rx;
   logic [REG_AW-1:0] r_rd_ry;
   logic [REG_AW-1:0] r_rd_rz;
   logic [3:0]        r_rd_op;
   logic              r_rd_we;
   // EX stage
   logic              r_ex_valid;
   logic [REG_AW-1:0] r_ex_rx;
   logic [3:0]        r_ex_op;
   logic              r_ex_we;
   logic [DATA_W-1:0] r_ex_a;
   logic [DATA_W-1:0] r_ex_b;
   // WB stage
   logic              r_wb_valid;
   logic [REG_AW-1:0] r_wb_rx;
   logic              r_wb_we;
   logic [DATA_W-1:0] r_wb_result;

   logic              w_out_valid;
   logic              w_stall;
   logic [DATA_W-1:0] w_ex_result;
   logic              w_ex_op_ok;
   logic              w_ex_wr;
   logic [SH_W-1:0]   w_sh;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;

   assign w_out_valid = r_wb_valid & ~rst;
   assign w_stall     = w_out_valid & ~bus.out_ready;

   assign bus.in_ready   = ~w_stall;
   assign bus.out_valid  = w_out_valid;
   assign bus.result_out = rst ? '0 : r_wb_result;
   assign bus.out_rx     = rst ? '0 : r_wb_rx;
   assign bus.zero_flag  = ~rst & (r_wb_result == '0);

   // ALU
   assign w_sh = r_ex_b[SH_W-1:0];

   always_comb begin
      w_ex_result = '0;
      w_ex_op_ok  = 1'b1;
      case (r_ex_op)
         4'd0:  w_ex_result = r_ex_a + r_ex_b;
         4'd1:  w_ex_result = r_ex_a - r_ex_b;
         4'd2:  w_ex_result = r_ex_a & r_ex_b;
         4'd3:  w_ex_result = r_ex_a | r_ex_b;
         4'd4:  w_ex_result = r_ex_a ^ r_ex_b;
         4'd5:  w_ex_result = ~r_ex_a;
         4'd6:  w_ex_result = r_ex_a << w_sh;
         4'd7:  w_ex_result = r_ex_a >> w_sh;
         4'd8:  w_ex_result = $unsigned($signed(r_ex_a) >>> w_sh);
         4'd9:  w_ex_result = {{(DATA_W-1){1'b0}}, ($signed(r_ex_a) < $signed(r_ex_b))};
         4'd10: w_ex_result = {{(DATA_W-1){1'b0}}, (r_ex_a < r_ex_b)};
         4'd11: w_ex_result = r_ex_a;
`ifdef ALU_MUL_EN
         4'd12: w_ex_result = r_ex_a * r_ex_b;
`endif
         default: w_ex_op_ok = 1'b0;
      endcase
   end

   // Effective write: illegal opcodes and r0 (when hard-wired) never write, so
   // they must not be forwarded either.
   assign w_ex_wr = r_ex_we & w_ex_op_ok & ~((ZERO_R0 != 0) && (r_ex_rx == '0));

   // Operand selection in RD: EX result beats WB result beats register file.
   // WB forwarding also covers a register being written on this same edge.
   always_comb begin
      if ((ZERO_R0 != 0) && (r_rd_ry == '0)) begin
         w_op_a = '0;
      end else if (r_ex_valid && w_ex_wr && (r_ex_rx == r_rd_ry)) begin
         w_op_a = w_ex_result;
      end else if (r_wb_valid && r_wb_we && (r_wb_rx == r_rd_ry)) begin
         w_op_a = r_wb_result;
      end else begin
         w_op_a = r_regs[r_rd_ry];
      end
   end

   always_comb begin
      if ((ZERO_R0 != 0) && (r_rd_rz == '0)) begin
         w_op_b = '0;
      end else if (r_ex_valid && w_ex_wr && (r_ex_rx == r_rd_rz)) begin
         w_op_b = w_ex_result;
      end else if (r_wb_valid && r_wb_we && (r_wb_rx == r_rd_rz)) begin
         w_op_b = r_wb_result;
      end else begin
         w_op_b = r_regs[r_rd_rz];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_rx     <= '0;
         r_rd_ry     <= '0;
         r_rd_rz     <= '0;
         r_rd_op     <= '0;
         r_rd_we     <= 1'b0;
         r_ex_valid  <= 1'b0;
         r_ex_rx     <= '0;
         r_ex_op     <= '0;
         r_ex_we     <= 1'b0;
         r_ex_a      <= '0;
         r_ex_b      <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_rx     <= '0;
         r_wb_we     <= 1'b0;
         r_wb_result <= '0;
      end else begin
         // Retire: only happens on a non-stalled edge since out_ready is high.
         if (r_wb_valid && bus.out_ready && r_wb_we) begin
            r_regs[r_wb_rx] <= r_wb_result;
         end
         if (!w_stall) begin
            r_rd_valid  <= bus.in_valid;
            r_rd_rx     <= bus.rx;
            r_rd_ry     <= bus.ry;
            r_rd_rz     <= bus.rz;
            r_rd_op     <= bus.op;
            r_rd_we     <= bus.write_en;
            r_ex_valid  <= r_rd_valid;
            r_ex_rx     <= r_rd_rx;
            r_ex_op     <= r_rd_op;
            r_ex_we     <= r_rd_we;
            r_ex_a      <= w_op_a;
            r_ex_b      <= w_op_b;
            r_wb_valid  <= r_ex_valid;
            r_wb_rx     <= r_ex_rx;
            r_wb_we     <= w_ex_wr;
            r_wb_result <= w_ex_result;
         end
      end
   end
endmodule

// File: tb/tb_pipelined_exec_unit.sv
module tb_pipelined_exec_unit;
   localparam int DW = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd10;
   localparam logic [3:0] OP_MOV  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;
   localparam logic [3:0] OP_BAD  = 4'd14;

   logic clk;
   logic rst;

   pipelined_exec_unit_if #(.DATA_W(DW), .NUM_REGS(16)) bus ();

   pipelined_exec_unit #(.DATA_W(DW), .NUM_REGS(16), .ZERO_R0(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] res;
      logic [3:0]    rx;
      int            acc_cyc;
      bit            chk_lat;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] m_regs [16];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   bit            g_lat = 1'b0;
   bit            g_rand = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: architectural register file updated in program order.
   task automatic model_issue(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                              input logic [3:0] rz, input bit we, input bit lat);
      logic [DW-1:0] a, b, r;
      bit ok;
      exp_t e;
      a  = (ry == 0) ? '0 : m_regs[ry];
      b  = (rz == 0) ? '0 : m_regs[rz];
      ok = 1'b1;
      r  = '0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = ~a;
         4'd6:  r = a << b[4:0];
         4'd7:  r = a >> b[4:0];
         4'd8:  r = $unsigned($signed(a) >>> b[4:0]);
         4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd10: r = (a < b) ? 32'd1 : 32'd0;
         4'd11: r = a;
`ifdef ALU_MUL_EN
         4'd12: r = a * b;
`endif
         default: ok = 1'b0;
      endcase
      if (we && ok && rx != 0) m_regs[rx] = r;
      e.res = r; e.rx = rx; e.acc_cyc = cyc + 1; e.chk_lat = lat;
      q.push_back(e);
   endtask

   // One driven cycle: inputs set just after posedge, acceptance decided at negedge.
   task automatic step(input bit v, input logic [3:0] op, input logic [3:0] rx,
                       input logic [3:0] ry, input logic [3:0] rz, input bit we,
                       input bit ordy, output bit acc);
      bus.in_valid  = v;
      bus.op        = op;
      bus.rx        = rx;
      bus.ry        = ry;
      bus.rz        = rz;
      bus.write_en  = we;
      bus.out_ready = ordy;
      @(negedge clk);
      acc = v && bus.in_ready;
      if (acc) model_issue(op, rx, ry, rz, we, g_lat);
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] rx, input logic [3:0] ry,
                        input logic [3:0] rz, input bit we);
      bit acc = 1'b0;
      int tries = 0;
      while (!acc) begin
         step(1'b1, op, rx, ry, rz, we, g_rand ? ($urandom_range(0, 3) != 0) : 1'b1, acc);
         tries++;
         if (!acc && tries > 50) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", tries);
            break;
         end
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, ordy, acc);
   endtask

   task automatic rand_burst(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) != 0)
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 4) != 0);
         else
            idle(1, $urandom_range(0, 1) != 0);
      end
   endtask

   // Monitor / scoreboard
   bit            prev_stall = 1'b0;
   bit            prev_rst = 1'b1;
   logic [DW-1:0] prev_res;
   logic [3:0]    prev_rx;

   always @(negedge clk) begin
      exp_t e;
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, !(bus.out_valid && !bus.out_ready)});
      if (rst) begin
         check("out_valid_in_reset", {31'd0, bus.out_valid}, 32'd0);
      end else begin
         if (prev_stall && !prev_rst) begin
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_result", bus.result_out, prev_res);
            check("stall_rx", {28'd0, bus.out_rx}, {28'd0, prev_rx});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_output: got result %0h expected no output", bus.result_out);
            end else begin
               e = q.pop_front();
               check("result_out", bus.result_out, e.res);
               check("out_rx", {28'd0, bus.out_rx}, {28'd0, e.rx});
               check("zero_flag", {31'd0, bus.zero_flag}, {31'd0, e.res == 0});
               if (e.chk_lat) check("latency", cyc - e.acc_cyc, 32'd2);
            end
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_rst   = rst;
      prev_res   = bus.result_out;
      prev_rx    = bus.out_rx;
   end

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.op = '0; bus.rx = '0; bus.ry = '0; bus.rz = '0;
      bus.write_en = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_result", bus.result_out, 32'd0);
      check("rst_out_rx", {28'd0, bus.out_rx}, 32'd0);
      check("rst_zero_flag", {31'd0, bus.zero_flag}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;

      // Directed, out_ready held high: latency must be exactly 2 for every op.
      g_lat = 1'b1;
      issue(OP_ADD, 4'd1, 4'd0, 4'd0, 1'b1);     // 0, zero_flag
      issue(OP_NOT, 4'd8, 4'd0, 4'd0, 1'b1);     // all ones
      issue(OP_SLTU, 4'd9, 4'd0, 4'd8, 1'b1);    // 1
      issue(OP_ADD, 4'd10, 4'd9, 4'd9, 1'b1);    // 2
      issue(OP_ADD, 4'd11, 4'd10, 4'd10, 1'b1);  // 4
      issue(OP_ADD, 4'd12, 4'd11, 4'd9, 1'b1);   // 5
      issue(OP_MOV, 4'd2, 4'd12, 4'd0, 1'b1);    // r2 = 5
      issue(OP_ADD, 4'd12, 4'd11, 4'd10, 1'b1);  // 6
      issue(OP_ADD, 4'd3, 4'd12, 4'd9, 1'b1);    // r3 = 7
      issue(OP_ADD, 4'd4, 4'd2, 4'd3, 1'b1);     // 12
      issue(OP_SUB, 4'd5, 4'd4, 4'd2, 1'b1);     // 7, EX forward
      issue(OP_ADD, 4'd6, 4'd2, 4'd3, 1'b1);     // 12
      issue(OP_ADD, 4'd13, 4'd9, 4'd9, 1'b1);    // unrelated
      issue(OP_XOR, 4'd7, 4'd6, 4'd6, 1'b1);     // 0, WB forward
      issue(OP_ADD, 4'd0, 4'd2, 4'd3, 1'b1);     // write to r0 dropped
      issue(OP_BAD, 4'd5, 4'd2, 4'd3, 1'b1);     // result 0, r5 kept
      issue(OP_MOV, 4'd14, 4'd0, 4'd0, 1'b1);    // r0 reads 0
      issue(OP_MOV, 4'd15, 4'd5, 4'd0, 1'b1);    // r5 still 7
      issue(OP_MUL, 4'd1, 4'd8, 4'd10, 1'b1);    // FFFFFFFE or 0/no write
      issue(OP_MOV, 4'd13, 4'd1, 4'd0, 1'b1);
      idle(3, 1'b1);

      // Backpressure with three in flight
      g_lat = 1'b0;
      issue(OP_ADD, 4'd4, 4'd4, 4'd9, 1'b1);
      issue(OP_ADD, 4'd4, 4'd4, 4'd9, 1'b1);
      issue(OP_ADD, 4'd6, 4'd4, 4'd4, 1'b1);
      idle(1, 1'b0);
      @(negedge clk);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
      idle(2, 1'b0);
      idle(4, 1'b1);
      issue(OP_MOV, 4'd7, 4'd6, 4'd0, 1'b1);
      issue(OP_MOV, 4'd7, 4'd4, 4'd0, 1'b1);

      // Random traffic with random backpressure
      g_rand = 1'b1;
      rand_burst(300);

      // Reset mid-stream
      rand_burst(6);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      q.delete();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      g_rand = 1'b0;
      for (int i = 1; i < 16; i++) issue(OP_MOV, 4'(i), 4'(i), 4'd0, 1'b1);
      g_rand = 1'b1;
      rand_burst(150);

      // Drain
      g_rand = 1'b0;
      for (int i = 0; i < 40 && q.size() != 0; i++) idle(1, 1'b1);
      check("drain_empty", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
